regfile_dump: RTL

Debug readout engine for the 32 x 32-bit register file. On a start pulse it walks register indices 0..NREGS-1 through one register-file read port and streams each (index, value) pair out over a valid/ready handshake to a debug or trace consumer. It sits beside the CPU datapath and drives a read address into the register file, whose read ports are combinational. It is the reader counterpart to the register file's write path.

---
 rtl/regfile_dump_if.sv | 50 +++++
 rtl/regfile_dump.sv | 110 +++++++++++
 2 files changed

// File: rtl/regfile_dump_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump_if
// Brief    : Start/status, register-file read port and word stream of the dump engine
// Revision : 1.0
// ============================================================================
interface regfile_dump_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          start;
  logic          busy;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_index;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          done;

  // Engine side: issues read addresses and produces the word stream.
  modport master (
    input  start,
    input  rd_data,
    input  out_ready,
    output busy,
    output rd_addr,
    output out_valid,
    output out_index,
    output out_data,
    output out_last,
    output done
  );

  // Environment side: register file, requester and stream consumer.
  modport slave (
    output start,
    output rd_data,
    output out_ready,
    input  busy,
    input  rd_addr,
    input  out_valid,
    input  out_index,
    input  out_data,
    input  out_last,
    input  done
  );
endinterface
`default_nettype wire

// File: rtl/regfile_dump.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump
// Brief    : Walks register indices 0..NREGS-1 and streams (index, value) pairs
// Revision : 1.0
// ============================================================================
module regfile_dump #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  wire logic      clk,
  input  wire logic      reset,
  regfile_dump_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2
  } state_t;

  localparam logic [AW-1:0] C_LAST_IDX = AW'(NREGS - 1);

  state_t        r_state,     w_state_nxt;
  logic [AW-1:0] r_idx,       w_idx_nxt;
  logic          r_out_valid, w_out_valid_nxt;
  logic [AW-1:0] r_out_index, w_out_index_nxt;
  logic [DW-1:0] r_out_data,  w_out_data_nxt;
  logic          r_out_last,  w_out_last_nxt;
  logic          r_done,      w_done_nxt;
  logic [AW-1:0] w_rd_addr;
  logic          w_accept;

  assign w_accept = r_out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_index <= '0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_index <= w_out_index_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_last  <= w_out_last_nxt;
      r_done      <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_out_valid_nxt = r_out_valid;
    w_out_index_nxt = r_out_index;
    w_out_data_nxt  = r_out_data;
    w_out_last_nxt  = r_out_last;
    w_done_nxt      = 1'b0;
    w_rd_addr       = r_idx;

    case (r_state)
      S_IDLE: begin
        w_rd_addr = '0;
        if (bus.start) begin
          w_idx_nxt   = '0;
          w_state_nxt = S_LOAD;
        end
      end
      // Sampling here means a same-edge write to this index is not seen.
      S_LOAD: begin
        w_out_data_nxt  = bus.rd_data;
        w_out_index_nxt = r_idx;
        w_out_valid_nxt = 1'b1;
        w_out_last_nxt  = (r_idx == C_LAST_IDX);
        w_state_nxt     = S_SEND;
      end
      S_SEND: begin
        if (w_accept) begin
          w_out_valid_nxt = 1'b0;
          if (r_idx == C_LAST_IDX) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_idx_nxt   = r_idx + 1'b1;
            w_state_nxt = S_LOAD;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.rd_addr   = w_rd_addr;
  assign bus.out_valid = r_out_valid;
  assign bus.out_index = r_out_index;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign bus.done      = r_done;

endmodule
`default_nettype wire
